// File: rtl/md_sched_pkg.sv
// Shared HI/LO multiply/divide definitions (the md_defs set): op and state encodings
// used by the scheduler, the mul/div datapath and the decoder.
package md_sched_pkg;

  localparam logic [3:0] MD_MUL  = 4'b1000;
  localparam logic [3:0] MD_MULU = 4'b1001;
  localparam logic [3:0] MD_DIV  = 4'b1010;
  localparam logic [3:0] MD_DIVU = 4'b1011;
  localparam logic [3:0] MD_MTHI = 4'b1100;
  localparam logic [3:0] MD_MTLO = 4'b1101;

  localparam logic [1:0] MDS_IDLE = 2'd0;
  localparam logic [1:0] MDS_MUL  = 2'd1;
  localparam logic [1:0] MDS_DIV  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = MDS_IDLE,
    StMul  = MDS_MUL,
    StDiv  = MDS_DIV
  } md_state_e;

  // MUL/MULU/DIV/DIVU all share the 10xx prefix.
  function automatic logic is_md_op(logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  function automatic logic is_mt_op(logic [3:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// E/D-stage to mul/div scheduler bundle.
//   master: pipeline side, drives e_valid/e_flush/e_md_op/d_uses_md, observes the rest.
//   slave : md_sched, consumes the stage signals, drives strobes, status and stall.
interface md_sched_if;
  logic       e_valid;
  logic       e_flush;
  logic [3:0] e_md_op;
  logic       d_uses_md;
  logic       md_start;
  logic [3:0] md_op;
  logic       md_wr_hi;
  logic       md_wr_lo;
  logic       busy;
  logic       done;
  logic       stall_d;
  logic       proto_err;

  modport master (
    output e_valid, e_flush, e_md_op, d_uses_md,
    input  md_start, md_op, md_wr_hi, md_wr_lo, busy, done, stall_d, proto_err
  );

  modport slave (
    input  e_valid, e_flush, e_md_op, d_uses_md,
    output md_start, md_op, md_wr_hi, md_wr_lo, busy, done, stall_d, proto_err
  );
endinterface

// File: rtl/md_sched_countdown.sv
// Busy countdown for the mul/div unit: load, decrement toward zero, detect the last cycle.
//   clk, rst_n  : clock, async active-low reset (count cleared)
//   load_i      : load load_val_i this edge (takes priority over decrement)
//   load_val_i  : latency to load
//   last_o      : count equals 1
module md_sched_countdown #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at zero rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/md_sched.sv
// HI/LO multiply/divide sequencing controller. Decodes the E-stage op, issues the
// start / HI / LO write strobes, tracks the fixed busy latency and raises the D-stage stall.
//   clk, rst_n : clock, async active-low reset
//   md         : md_sched_if.slave (stage inputs, strobes, busy/done, stall_d, proto_err)
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  md_sched_if.slave   md
);

  md_state_e        state_q;
  logic             proto_q;
  logic             req, is_md, is_mt, idle, start, cnt_last;
  logic [CNT_W-1:0] lat;

  assign req   = md.e_valid & ~md.e_flush;
  assign is_md = is_md_op(md.e_md_op);
  assign is_mt = is_mt_op(md.e_md_op);
  assign idle  = (state_q == StIdle);
  assign start = idle & req & is_md;

  // op[1] separates DIV/DIVU from MUL/MULU.
  assign lat = md.e_md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

  md_sched_countdown #(
    .CNT_W (CNT_W)
  ) u_countdown (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (start),
    .load_val_i (lat),
    .last_o     (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      proto_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_q <= md.e_md_op[1] ? StDiv : StMul;
        end
        StMul, StDiv: begin
          // Flushes never abort a running op; the countdown simply finishes.
          if (cnt_last) state_q <= StIdle;
          // stall_d should have held this instruction in D.
          if (req & (is_md | is_mt)) proto_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign md.md_start  = start;
  assign md.md_op     = start ? md.e_md_op : 4'b0000;
  assign md.md_wr_hi  = idle & req & (md.e_md_op == MD_MTHI);
  assign md.md_wr_lo  = idle & req & (md.e_md_op == MD_MTLO);
  assign md.busy      = ~idle;
  assign md.done      = ~idle & cnt_last;
  // Also stall when the op starts this very cycle (e.g. MFHI in D behind MUL in E).
  assign md.stall_d   = md.d_uses_md & (~idle | (req & is_md));
  assign md.proto_err = proto_q;

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md_sched_if ifc ();

  md_sched #(
    .MUL_LAT (5),
    .DIV_LAT (10),
    .CNT_W   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (ifc)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: cycles of busy remaining, and the sticky protocol flag.
  int m_left  = 0;
  bit m_proto = 0;

  logic [10:0] obs;
  assign obs = {ifc.md_start, ifc.md_op, ifc.md_wr_hi, ifc.md_wr_lo,
                ifc.busy, ifc.done, ifc.stall_d, ifc.proto_err};

  function automatic logic [10:0] exp_vec();
    logic req, ismd, st;
    req  = ifc.e_valid & ~ifc.e_flush;
    ismd = (ifc.e_md_op >= 4'd8) && (ifc.e_md_op <= 4'd11);
    st   = (m_left == 0) && req && ismd;
    return {st, (st ? ifc.e_md_op : 4'd0),
            (m_left == 0) && req && (ifc.e_md_op == 4'd12),
            (m_left == 0) && req && (ifc.e_md_op == 4'd13),
            (m_left > 0), (m_left == 1),
            ifc.d_uses_md && ((m_left > 0) || (req && ismd)),
            m_proto};
  endfunction

  task automatic drive(input logic v, input logic f, input logic [3:0] op, input logic d);
    ifc.e_valid   = v;
    ifc.e_flush   = f;
    ifc.e_md_op   = op;
    ifc.d_uses_md = d;
  endtask

  // Advance one clock and step the model with the inputs held across the edge.
  task automatic tick();
    logic req, ismd, ismt;
    @(posedge clk);
    if (rst_n) begin
      req  = ifc.e_valid & ~ifc.e_flush;
      ismd = (ifc.e_md_op >= 4'd8) && (ifc.e_md_op <= 4'd11);
      ismt = (ifc.e_md_op == 4'd12) || (ifc.e_md_op == 4'd13);
      if (m_left == 0) begin
        if (req && ismd) m_left = ifc.e_md_op[1] ? 10 : 5;
      end else begin
        if (req && (ismd || ismt)) m_proto = 1'b1;
        m_left = m_left - 1;
      end
    end
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    m_left  = 0;
    m_proto = 0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    checks++;
    if (obs !== 11'b0) begin
      errors++;
      $display("FAIL reset_idle obs=%b exp=%b", obs, 11'b0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    // DIV start, one illegal MTLO, then run down to cnt=6 and reset asynchronously.
    drive(1'b1, 1'b0, 4'b1010, 1'b0);
    #1;
    checks++;
    if (obs !== exp_vec() || ifc.md_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_div_start obs=%b exp=%b", obs, exp_vec());
    end
    tick();
    drive(1'b1, 1'b0, 4'b1101, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (ifc.busy !== 1'b1 || ifc.proto_err !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre busy=%b proto=%b exp busy=1 proto=1", ifc.busy, ifc.proto_err);
    end
    #2 rst_n = 1'b0;
    #1;
    m_left  = 0;
    m_proto = 0;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async busy=%b done=%b proto=%b exp all 0",
               ifc.busy, ifc.done, ifc.proto_err);
    end
    #1 rst_n = 1'b1;
    tick();
    drive(1'b1, 1'b0, 4'b1000, 1'b0);
    #1;
    checks++;
    if (ifc.md_start !== 1'b1 || ifc.md_op !== 4'b1000 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_next_mul start=%b op=%b busy=%b exp 1 1000 0",
               ifc.md_start, ifc.md_op, ifc.busy);
    end
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_mulu();
    drive(1'b1, 1'b0, 4'b1001, 1'b0);
    #1;
    checks++;
    if (ifc.md_start !== 1'b1 || ifc.md_op !== 4'b1001 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL mulu_start obs=%b exp=%b", obs, exp_vec());
    end
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      #1;
      checks++;
      if (ifc.busy !== (i <= 5) || ifc.done !== (i == 5) || obs !== exp_vec()) begin
        errors++;
        $display("FAIL mulu_cyc%0d busy=%b done=%b exp busy=%b done=%b",
                 i, ifc.busy, ifc.done, (i <= 5), (i == 5));
      end
      tick();
    end
  endtask

  task automatic test_div_stall();
    drive(1'b1, 1'b0, 4'b1010, 1'b1);
    #1;
    checks++;
    if (ifc.stall_d !== 1'b1 || ifc.md_start !== 1'b1) begin
      errors++;
      $display("FAIL div_stall_start stall=%b start=%b exp 1 1", ifc.stall_d, ifc.md_start);
    end
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 1; i <= 11; i++) begin
      #1;
      checks++;
      if (ifc.stall_d !== (i <= 10) || ifc.busy !== (i <= 10) || obs !== exp_vec()) begin
        errors++;
        $display("FAIL div_stall_cyc%0d stall=%b busy=%b exp %b", i, ifc.stall_d, ifc.busy,
                 (i <= 10));
      end
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_mthi_flush();
    drive(1'b1, 1'b1, 4'b1100, 1'b0);
    #1;
    checks++;
    if (ifc.md_wr_hi !== 1'b0 || ifc.md_start !== 1'b0) begin
      errors++;
      $display("FAIL mthi_flushed wr_hi=%b start=%b exp 0 0", ifc.md_wr_hi, ifc.md_start);
    end
    tick();
    drive(1'b1, 1'b0, 4'b1100, 1'b0);
    #1;
    checks++;
    if (ifc.md_wr_hi !== 1'b1 || ifc.md_wr_lo !== 1'b0 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL mthi_write wr_hi=%b wr_lo=%b exp 1 0", ifc.md_wr_hi, ifc.md_wr_lo);
    end
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    checks++;
    if (ifc.md_wr_hi !== 1'b0 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi_after wr_hi=%b busy=%b exp 0 0", ifc.md_wr_hi, ifc.busy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 4'b1000, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    drive(1'b1, 1'b0, 4'b1011, 1'b0);
    #1;
    checks++;
    if (ifc.md_start !== 1'b1 || ifc.md_op !== 4'b1011 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start start=%b op=%b busy=%b exp 1 1011 0",
               ifc.md_start, ifc.md_op, ifc.busy);
    end
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      #1;
      checks++;
      if (ifc.busy !== 1'b1 || ifc.done !== (i == 10) || ifc.proto_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_cyc%0d busy=%b done=%b proto=%b exp 1 %b 0",
                 i, ifc.busy, ifc.done, ifc.proto_err, (i == 10));
      end
      tick();
    end
  endtask

  task automatic test_proto();
    drive(1'b1, 1'b0, 4'b1010, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    // Countdown is now at 4.
    drive(1'b1, 1'b0, 4'b1000, 1'b0);
    #1;
    checks++;
    if (ifc.md_start !== 1'b0 || ifc.md_op !== 4'b0000 || ifc.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_nostart start=%b op=%b proto=%b exp 0 0000 0",
               ifc.md_start, ifc.md_op, ifc.proto_err);
    end
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      #1;
      checks++;
      if (ifc.proto_err !== 1'b1 || ifc.busy !== (j < 3) || ifc.done !== (j == 2)) begin
        errors++;
        $display("FAIL proto_cyc%0d proto=%b busy=%b done=%b exp 1 %b %b",
                 j, ifc.proto_err, ifc.busy, ifc.done, (j < 3), (j == 2));
      end
      tick();
    end
    pulse_reset();
  endtask

  task automatic test_random();
    logic v, f, d;
    logic [3:0] op;
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 50) pulse_reset();
      op = 4'($urandom_range(0, 15));
      v  = ($urandom_range(0, 9) < 7);
      f  = ($urandom_range(0, 9) < 2);
      d  = 1'($urandom_range(0, 1));
      // Mostly behave like a pipeline that honours the stall.
      if (m_left > 0 && $urandom_range(0, 9) < 8) v = 1'b0;
      drive(v, f, op, d);
      #1;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random_cyc%0d obs=%b exp=%b", i, obs, exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    test_reset();
    test_mulu();
    test_div_stall();
    test_mthi_flush();
    test_back_to_back();
    test_proto();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
